// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//
// Shared definitions for the stage sequencer: sequencer state encoding,
// number of stages, stage index constants and a one-hot helper.
//
// Stage bit order used on every per-stage vector (stage_done, stage_rst,
// stage_start):
//   [0] memory load, [1] PE array, [2] 3x3 stage, [3] 2x2 stage, [4] display
//
// No ports (package).
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int N_STAGE = 5;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] STG_MEM  = 3'd0;
  localparam logic [IDX_W-1:0] STG_PE   = 3'd1;
  localparam logic [IDX_W-1:0] STG_3B3  = 3'd2;
  localparam logic [IDX_W-1:0] STG_2B2  = 3'd3;
  localparam logic [IDX_W-1:0] STG_DISP = 3'd4;

  // All stages held in reset.
  localparam logic [N_STAGE-1:0] ALL_RST = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_e;

  // One-hot vector with bit i set; i is always a valid stage index here.
  function automatic logic [N_STAGE-1:0] stage_onehot(input logic [IDX_W-1:0] i);
    logic [N_STAGE-1:0] one;
    one = {{(N_STAGE-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
//
// Saturating per-stage cycle counter for the stage sequencer. Cleared while
// a stage is being started, counts every enabled cycle afterwards and stops
// at TIMEOUT_CYC-1, where it raises `expired` and stays there (never wraps).
//
// Only built when SEQ_TIMEOUT_EN is defined; without the watchdog the
// sequencer has no use for it.
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed before expiry
//   TIMEOUT_W    counter width
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr      in   clear counter to 0 (wins over en)
//   en       in   count this cycle
//   count    out  current count, TIMEOUT_W bits
//   expired  out  count has reached TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TIMEOUT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [TIMEOUT_W-1:0] count,
  output logic                 expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule
`endif

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
//
// Releases the five pipeline stages (mem, pe, 3b3, 2b2, disp) from reset one
// at a time, starts each with a one-cycle pulse and waits for its done before
// moving to the next. After the display stage reports done every stage stays
// out of reset and `done` is held until a new `go`.
//
// Stage handshake: for the active stage idx, stage_start[idx] is a one-cycle
// pulse in the START cycle; the stage answers by holding or raising
// stage_done[idx] in any later cycle. Done is only sampled in WAIT, only for
// the active stage; a done seen during the START cycle is ignored. Done acts
// as a level: one cycle high in WAIT is enough to advance.
//
// Optional feature, macro SEQ_TIMEOUT_EN:
//   defined   - a watchdog counts WAIT cycles; reaching TIMEOUT_CYC-1 without
//               done enters ERR (all stages in reset, err=1, cur_stage keeps
//               the failing index). Done on the expiry cycle still advances.
//   undefined - WAIT waits forever, ERR is unreachable and err is tied to 0;
//               TIMEOUT_CYC / TIMEOUT_W are unused.
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed per stage from its start pulse
//   TIMEOUT_W    watchdog counter width
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   go           in   start request, sampled in IDLE, FINISH and ERR
//   stage_done   in   per-stage completion [4:0]
//   stage_rst    out  per-stage reset, 1 = held in reset [4:0]
//   stage_start  out  one-hot one-cycle start pulse [4:0]
//   cur_stage    out  active stage index (failing index in ERR)
//   busy         out  high in START and WAIT
//   done         out  high in FINISH
//   err          out  high in ERR
//
// All outputs come straight from flops; none depends combinationally on an
// input.
// ---------------------------------------------------------------------------
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TIMEOUT_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [4:0]   stage_done,
  output logic [4:0]   stage_rst,
  output logic [4:0]   stage_start,
  output logic [2:0]   cur_stage,
  output logic         busy,
  output logic         done,
  output logic         err
);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [N_STAGE-1:0] stage_rst_d;
  logic [N_STAGE-1:0] stage_start_d;
  logic               busy_d;
  logic               done_d;
  logic               err_d;

  logic               wd_expired;

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
  localparam logic ERR_EN = 1'b1;

  logic                 wd_clr;
  logic                 wd_en;
  logic [TIMEOUT_W-1:0] wd_count_unused;

  // Cleared during the START cycle so the first WAIT cycle sees count 0;
  // the stage therefore gets exactly TIMEOUT_CYC WAIT cycles.
  assign wd_clr = (state_q == ST_START);
  assign wd_en  = (state_q == ST_WAIT);

  seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .count   (wd_count_unused),
    .expired (wd_expired)
  );
`else
  localparam logic ERR_EN = 1'b0;

  logic unused_timeout_cfg;

  assign wd_expired         = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0) ^ (TIMEOUT_W == 0);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_START;
          idx_d   = STG_MEM;
        end
      end

      ST_FLUSH: begin
        state_d = ST_START;
        idx_d   = STG_MEM;
      end

      ST_START: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Done is checked before expiry so a done on the expiry cycle wins.
        if (stage_done[idx_q]) begin
          if (idx_q == STG_DISP) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_START;
            idx_d   = idx_q + 3'd1;
          end
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_FINISH, ST_ERR: begin
        if (go) begin
          state_d = ST_FLUSH;
          idx_d   = STG_MEM;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = STG_MEM;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, so every output is a flop
  // -------------------------------------------------------------------------
  always_comb begin
    stage_rst_d   = ALL_RST;
    stage_start_d = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_d)
      ST_START: begin
        // Released stages stay released; only the newly started one clears.
        stage_rst_d   = stage_rst & ~stage_onehot(idx_d);
        stage_start_d = stage_onehot(idx_d);
        busy_d        = 1'b1;
      end

      ST_WAIT: begin
        stage_rst_d = stage_rst;
        busy_d      = 1'b1;
      end

      ST_FINISH: begin
        // Display keeps running after the run completes.
        stage_rst_d = '0;
        done_d      = 1'b1;
      end

      ST_ERR: begin
        err_d = ERR_EN;
      end

      default: begin
        stage_rst_d = ALL_RST;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= STG_MEM;
      stage_rst   <= ALL_RST;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_rst   <= stage_rst_d;
      stage_start <= stage_start_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // idx is a register; in ERR it is frozen at the failing stage.
  assign cur_stage = idx_q;

endmodule
